// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the program counter, drives instruction-memory addresses and
// pairs each returned word with its PC for decode, honouring stall, redirect and halt.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013,
  parameter logic [31:0] HALT_INST = 32'h0000_0000
) (
  input  logic        clk_50,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o,
  output logic        halted_o,
  output logic [31:0] fetch_count_o
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] rsp_pc_q;
  logic        rsp_valid_q;
  logic [31:0] cnt_q;

  logic [31:0] tgt;
  logic        is_halt;
  logic        hold_out;

  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  assign tgt      = {redirect_pc_i[31:2], 2'b00};
  assign is_halt  = rsp_valid_q && (imem_inst == HALT_INST);
  assign hold_out = stall_i && if_valid_o;

  assign if_pc_o       = rsp_pc_q;
  assign if_inst_o     = rsp_valid_q ? imem_inst : NOP_INST;
  assign if_valid_o    = rsp_valid_q && (state == RUN) && !is_halt && !redirect_i;
  assign halted_o      = (state == HALT);
  assign fetch_count_o = cnt_q;

  // Re-presenting rsp_pc_q keeps imem_inst stable while the word is held or halted.
  always_comb begin
    imem_addr = pc_q;
    if (redirect_i)
      imem_addr = tgt;
    else if (state == HALT)
      imem_addr = rsp_pc_q;
    else if (hold_out)
      imem_addr = rsp_pc_q;
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc_q        <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      rsp_valid_q <= 1'b0;
      cnt_q       <= 32'd0;
    end else begin
      if (if_valid_o && !stall_i)
        cnt_q <= cnt_q + 32'd1;

      if (redirect_i) begin
        rsp_pc_q    <= tgt;
        pc_q        <= pc_incr(tgt);
        rsp_valid_q <= 1'b1;
        state       <= RUN;
      end else if (state == HALT) begin
        state <= HALT;
      end else if (is_halt) begin
        state       <= HALT;
        rsp_valid_q <= 1'b1;
      end else if (!hold_out) begin
        // A stalled bubble still advances so decode never waits on an empty slot.
        rsp_pc_q    <= pc_q;
        pc_q        <= pc_incr(pc_q);
        rsp_valid_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a 1-cycle-latency memory model plus a
// scoreboard of PCs expected to be handed to decode.
module tb_inst_fetch_unit;

  logic        clk_50;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;
  logic        halted_o;
  logic [31:0] fetch_count_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem [256];
  logic [31:0] exp_q [$];

  inst_fetch_unit dut (
    .clk_50        (clk_50),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_inst     (imem_inst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .if_pc_o       (if_pc_o),
    .if_inst_o     (if_inst_o),
    .if_valid_o    (if_valid_o),
    .halted_o      (halted_o),
    .fetch_count_o (fetch_count_o)
  );

  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  function automatic logic [31:0] word(input int i);
    if (i < 5)        return 32'h0000_0013;
    else if (i == 5)  return 32'hff81_0113;
    else if (i == 6)  return 32'h0141_2223;
    else if (i == 15) return 32'h0000_0513;
    else if (i == 42) return 32'h0000_0000;
    else              return 32'hA000_0000 | i;
  endfunction

  always @(posedge clk_50) imem_inst <= mem[imem_addr[9:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50);
    #5;
  endtask

  task automatic push_run(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(4 * i));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'b0, if_valid_o}, 32'd0);
    chk({tag, "_pc"}, if_pc_o, 32'h0);
    chk({tag, "_inst"}, if_inst_o, 32'h0000_0013);
    chk({tag, "_halted"}, {31'b0, halted_o}, 32'd0);
    chk({tag, "_count"}, fetch_count_o, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
  endtask

  // Scoreboard: every handoff to decode must match the next expected PC.
  always @(negedge clk_50) begin
    if (if_valid_o && !stall_i) begin
      logic [31:0] pc_e;
      chk("sb_pending", {31'b0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        pc_e = exp_q.pop_front();
        chk("sb_pc", if_pc_o, pc_e);
        chk("sb_inst", if_inst_o, word(int'(pc_e[9:2])));
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = word(i);
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 32'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk_reset_outputs("reset");

    // Test 1: straight fetch from RESET_PC
    repeat (2) @(posedge clk_50);
    #5;
    rst_n = 1'b1;
    push_run(32'd0, 6);
    tick();
    chk("t1_valid", {31'b0, if_valid_o}, 32'd1);
    chk("t1_pc0", if_pc_o, 32'd0);
    chk("t1_inst0", if_inst_o, 32'h0000_0013);
    repeat (5) tick();
    chk("t1_pc20", if_pc_o, 32'd20);
    chk("t1_inst20", if_inst_o, 32'hff81_0113);

    // Test 2: stall holds the output for 3 edges
    stall_i = 1'b1;
    #1;
    chk("t2_addr_hold", imem_addr, 32'd20);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_pc_hold", if_pc_o, 32'd20);
      chk("t2_inst_hold", if_inst_o, 32'hff81_0113);
      chk("t2_addr", imem_addr, 32'd20);
      chk("t2_count", fetch_count_o, 32'd5);
    end
    stall_i = 1'b0;
    push_run(32'd24, 28);
    tick();
    chk("t2_pc24", if_pc_o, 32'd24);
    chk("t2_inst24", if_inst_o, 32'h0141_2223);
    chk("t2_count_after", fetch_count_o, 32'd6);
    repeat (28) tick();
    chk("t3_at136", if_pc_o, 32'd136);

    // Test 3: redirect with unaligned target
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_003F;
    #1;
    chk("t3_kill", {31'b0, if_valid_o}, 32'd0);
    chk("t3_addr", imem_addr, 32'd60);
    tick();
    redirect_i = 1'b0;
    #1;
    chk("t3_pc", if_pc_o, 32'd60);
    chk("t3_inst", if_inst_o, 32'h0000_0513);
    chk("t3_valid", {31'b0, if_valid_o}, 32'd1);

    // Test 4: redirect and stall together
    redirect_i = 1'b1;
    stall_i = 1'b1;
    redirect_pc_i = 32'd200;
    #1;
    chk("t4_addr", imem_addr, 32'd200);
    chk("t4_kill", {31'b0, if_valid_o}, 32'd0);
    exp_q.push_back(32'd200);
    tick();
    redirect_i = 1'b0;
    stall_i = 1'b0;
    #1;
    chk("t4_pc", if_pc_o, 32'd200);
    chk("t4_valid", {31'b0, if_valid_o}, 32'd1);
    tick();
    chk("t4_pc204", if_pc_o, 32'd204);

    // Test 6: async reset mid-run at pc 100
    redirect_i = 1'b1;
    redirect_pc_i = 32'd80;
    push_run(32'd80, 5);
    tick();
    redirect_i = 1'b0;
    repeat (5) tick();
    chk("t6_at100", if_pc_o, 32'd100);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6_async");
    #2;
    rst_n = 1'b1;

    // Test 5: straight-line run into HALT_INST at 168
    push_run(32'd0, 42);
    repeat (43) tick();
    chk("t5_pc168", if_pc_o, 32'd168);
    chk("t5_halt_word_killed", {31'b0, if_valid_o}, 32'd0);
    chk("t5_not_yet_halted", {31'b0, halted_o}, 32'd0);
    chk("t5_count", fetch_count_o, 32'd42);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t5_halted", {31'b0, halted_o}, 32'd1);
      chk("t5_addr_hold", imem_addr, 32'd168);
      chk("t5_valid_off", {31'b0, if_valid_o}, 32'd0);
      chk("t5_count_hold", fetch_count_o, 32'd42);
    end
    redirect_i = 1'b1;
    redirect_pc_i = 32'd0;
    push_run(32'd0, 2);
    #1;
    chk("t5_redir_addr", imem_addr, 32'd0);
    tick();
    redirect_i = 1'b0;
    #1;
    chk("t5_resume_halted", {31'b0, halted_o}, 32'd0);
    chk("t5_resume_pc", if_pc_o, 32'd0);
    chk("t5_resume_valid", {31'b0, if_valid_o}, 32'd1);
    tick();
    chk("t5_resume_pc4", if_pc_o, 32'd4);
    @(negedge clk_50);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
